// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: one memory port shared by fetch (IF) and load/store (LS).
// Ports: if_* / ls_* req-gnt-rvalid requesters, mem_* req-ack port, busy.
// One access in flight; build with ARB_RR_EN for round-robin arbitration.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                ls_req,
  input  logic                ls_we,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic [DATA_W-1:0]   ls_wdata,
  input  logic [DATA_W/8-1:0] ls_be,
  output logic                ls_gnt,
  output logic                ls_rvalid,
  output logic [DATA_W-1:0]   ls_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY_IF,
    BUSY_LS,
    DONE
  } state_t;

  state_t state, state_nxt;
  logic   owner_ls;
  logic   pick_ls;

`ifdef ARB_RR_EN
  logic last_ls;

  // Under contention, favour whoever lost last time.
  assign pick_ls = ls_req && (!if_req || !last_ls);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_ls <= 1'b0;
    end else if (if_gnt || ls_gnt) begin
      last_ls <= ls_gnt;
    end
  end
`else
  assign pick_ls = ls_req;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if_gnt    = 1'b0;
    ls_gnt    = 1'b0;
    unique case (state)
      IDLE: begin
        if (ls_req || if_req) begin
          ls_gnt    = pick_ls;
          if_gnt    = !pick_ls;
          state_nxt = pick_ls ? BUSY_LS : BUSY_IF;
        end
      end
      BUSY_IF, BUSY_LS: begin
        if (mem_ack) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Request fields are captured at grant and held for the access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      owner_ls  <= 1'b0;
    end else if (ls_gnt) begin
      mem_we    <= ls_we;
      mem_addr  <= ls_addr;
      mem_wdata <= ls_wdata;
      mem_be    <= ls_be;
      owner_ls  <= 1'b1;
    end else if (if_gnt) begin
      mem_we    <= 1'b0;
      mem_addr  <= if_addr;
      mem_be    <= '1;
      owner_ls  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_rdata <= '0;
      ls_rdata <= '0;
    end else if (mem_ack) begin
      if (state == BUSY_IF) begin
        if_rdata <= mem_rdata;
      end
      if (state == BUSY_LS) begin
        ls_rdata <= mem_we ? '0 : mem_rdata;
      end
    end
  end

  assign mem_req   = (state == BUSY_IF) || (state == BUSY_LS);
  assign busy      = (state != IDLE);
  assign if_rvalid = (state == DONE) && !owner_ls;
  assign ls_rvalid = (state == DONE) && owner_ls;

endmodule
